// File: rtl/auto_exposure_controller.sv
// Frame-mean luma exposure loop: measures each frame, nudges exposure by STEP, requests a config write.
// Decision 2 cycles after frame_end; pulse waits for bus_active low and a 1-cycle hold after any output change.
module auto_exposure_controller #(
    parameter logic [7:0] TARGET     = 8'd110,
    parameter logic [7:0] DEADBAND   = 8'd12,
    parameter logic [7:0] STEP       = 8'd4,
    parameter logic [7:0] EXP_INIT   = 8'h40,
    parameter logic [7:0] EXP_MIN    = 8'h04,
    parameter logic [7:0] EXP_MAX    = 8'hF0,
    parameter int         FRAME_SKIP = 2,
    parameter int         SUM_WIDTH  = 32,
    parameter int         CNT_WIDTH  = 20
) (
    input  logic       clk_camera,
    input  logic       sys_rst_camera_n,
    input  logic       ae_enable,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       pixel_valid,
    input  logic [7:0] pixel_luma,
    input  logic       bus_active,
    output logic [7:0] exposure,
    output logic       manual_exposure,
    output logic       ready_update_out,
    output logic       ae_busy
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_MEASURE, ST_CALC, ST_DECIDE, ST_UPDATE, ST_SETTLE
    } state_t;

    localparam logic [SUM_WIDTH-1:0] HI_MUL = SUM_WIDTH'({1'b0, TARGET} + {1'b0, DEADBAND});
    localparam logic [SUM_WIDTH-1:0] LO_MUL = SUM_WIDTH'({1'b0, TARGET} - {1'b0, DEADBAND});

    state_t               r_state;
    logic [7:0]           r_exposure;
    logic                 r_manual;
    logic                 r_ready;
    logic                 r_in_frame;
    logic [SUM_WIDTH-1:0] r_sum;
    logic [CNT_WIDTH-1:0] r_count;
    logic [SUM_WIDTH-1:0] r_hi_thr;
    logic [SUM_WIDTH-1:0] r_lo_thr;
    logic [7:0]           r_skip;
    logic                 r_hold;
    logic                 r_to_idle;

    logic [SUM_WIDTH:0]   w_sum_add;
    logic [SUM_WIDTH-1:0] w_sum_sat;
    logic [CNT_WIDTH-1:0] w_cnt_sat;
    logic [SUM_WIDTH-1:0] w_cnt_ext;
    logic [8:0]           w_exp_up9;
    logic [7:0]           w_exp_up;
    logic [7:0]           w_exp_dn;
    logic [7:0]           w_exp_new;

    assign w_sum_add = {1'b0, r_sum} + {{(SUM_WIDTH-7){1'b0}}, pixel_luma};
    assign w_sum_sat = w_sum_add[SUM_WIDTH] ? '1 : w_sum_add[SUM_WIDTH-1:0];
    assign w_cnt_sat = (&r_count) ? r_count : r_count + CNT_WIDTH'(1);
    assign w_cnt_ext = SUM_WIDTH'(r_count);

    // 9-bit arithmetic so the clamps see overflow/underflow instead of a wrapped value
    assign w_exp_up9 = {1'b0, r_exposure} + {1'b0, STEP};
    assign w_exp_up  = (w_exp_up9 > {1'b0, EXP_MAX}) ? EXP_MAX : w_exp_up9[7:0];
    assign w_exp_dn  = ({1'b0, r_exposure} < ({1'b0, EXP_MIN} + {1'b0, STEP})) ? EXP_MIN
                                                                               : r_exposure - STEP;

    always_comb begin
        w_exp_new = r_exposure;
        if (r_sum < r_lo_thr)
            w_exp_new = w_exp_up;
        else if (r_sum > r_hi_thr)
            w_exp_new = w_exp_dn;
    end

    always_ff @(posedge clk_camera) begin
        if (!sys_rst_camera_n) begin
            r_state    <= ST_IDLE;
            r_exposure <= EXP_INIT;
            r_manual   <= 1'b0;
            r_ready    <= 1'b0;
            r_in_frame <= 1'b0;
            r_sum      <= '0;
            r_count    <= '0;
            r_hi_thr   <= '0;
            r_lo_thr   <= '0;
            r_skip     <= '0;
            r_hold     <= 1'b0;
            r_to_idle  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (!ae_enable && r_state != ST_IDLE && !r_to_idle) begin
                // Hand control back: one final write with manual mode cleared
                r_manual   <= 1'b0;
                r_to_idle  <= 1'b1;
                r_hold     <= 1'b1;
                r_in_frame <= 1'b0;
                r_state    <= ST_UPDATE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (ae_enable) begin
                            r_manual <= 1'b1;
                            r_hold   <= 1'b1;
                            r_state  <= ST_UPDATE;
                        end
                    end
                    ST_MEASURE: begin
                        if (frame_start) begin
                            r_in_frame <= 1'b1;
                            r_sum      <= '0;
                            r_count    <= '0;
                        end else if (r_in_frame) begin
                            if (pixel_valid) begin
                                r_sum   <= w_sum_sat;
                                r_count <= w_cnt_sat;
                            end
                            if (frame_end) begin
                                r_in_frame <= 1'b0;
                                r_state    <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        r_hi_thr <= w_cnt_ext * HI_MUL;
                        r_lo_thr <= w_cnt_ext * LO_MUL;
                        r_state  <= ST_DECIDE;
                    end
                    ST_DECIDE: begin
                        if (r_count == '0 || w_exp_new == r_exposure) begin
                            r_state <= ST_MEASURE;
                        end else begin
                            r_exposure <= w_exp_new;
                            r_hold     <= 1'b1;
                            r_state    <= ST_UPDATE;
                        end
                    end
                    ST_UPDATE: begin
                        // r_hold keeps outputs stable for two cycles ahead of the pulse
                        if (r_hold) begin
                            r_hold <= 1'b0;
                        end else if (!bus_active) begin
                            r_ready <= 1'b1;
                            if (r_to_idle) begin
                                r_to_idle <= 1'b0;
                                r_state   <= ST_IDLE;
                            end else begin
                                r_skip  <= 8'(FRAME_SKIP);
                                r_state <= ST_SETTLE;
                            end
                        end
                    end
                    ST_SETTLE: begin
                        if (frame_end) begin
                            if (r_skip <= 8'd1)
                                r_state <= ST_MEASURE;
                            else
                                r_skip <= r_skip - 8'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign exposure         = r_exposure;
    assign manual_exposure  = r_manual;
    assign ready_update_out = r_ready;
    assign ae_busy          = (r_state != ST_IDLE) && (r_state != ST_MEASURE);

endmodule

// File: tb/tb_auto_exposure_controller.sv
// Directed bench for auto_exposure_controller: default instance plus two instances
// started near the exposure clamps (0xEE and 0x06) sharing the same stimulus.
module tb_auto_exposure_controller;
    logic       clk_camera = 1'b0;
    logic       sys_rst_camera_n;
    logic       ae_enable;
    logic       frame_start;
    logic       frame_end;
    logic       pixel_valid;
    logic [7:0] pixel_luma;
    logic       bus_active;

    logic [7:0] exp_m, exp_h, exp_l;
    logic       man_m, man_h, man_l;
    logic       rdy_m, rdy_h, rdy_l;
    logic       busy_m, busy_h, busy_l;

    auto_exposure_controller u_main (
        .clk_camera(clk_camera), .sys_rst_camera_n(sys_rst_camera_n), .ae_enable(ae_enable),
        .frame_start(frame_start), .frame_end(frame_end), .pixel_valid(pixel_valid),
        .pixel_luma(pixel_luma), .bus_active(bus_active), .exposure(exp_m),
        .manual_exposure(man_m), .ready_update_out(rdy_m), .ae_busy(busy_m)
    );

    auto_exposure_controller #(.EXP_INIT(8'hEE)) u_hi (
        .clk_camera(clk_camera), .sys_rst_camera_n(sys_rst_camera_n), .ae_enable(ae_enable),
        .frame_start(frame_start), .frame_end(frame_end), .pixel_valid(pixel_valid),
        .pixel_luma(pixel_luma), .bus_active(bus_active), .exposure(exp_h),
        .manual_exposure(man_h), .ready_update_out(rdy_h), .ae_busy(busy_h)
    );

    auto_exposure_controller #(.EXP_INIT(8'h06)) u_lo (
        .clk_camera(clk_camera), .sys_rst_camera_n(sys_rst_camera_n), .ae_enable(ae_enable),
        .frame_start(frame_start), .frame_end(frame_end), .pixel_valid(pixel_valid),
        .pixel_luma(pixel_luma), .bus_active(bus_active), .exposure(exp_l),
        .manual_exposure(man_l), .ready_update_out(rdy_l), .ae_busy(busy_l)
    );

    always #5 clk_camera = ~clk_camera;

    int   n_chk = 0;
    int   n_err = 0;
    int   p_main = 0;
    int   p_hi = 0;
    int   p_lo = 0;
    logic last_man = 1'b0;
    int   base_m, base_h, base_l;

    always @(negedge clk_camera) begin
        if (rdy_m) begin
            p_main   <= p_main + 1;
            last_man <= man_m;
        end
        if (rdy_h) p_hi <= p_hi + 1;
        if (rdy_l) p_lo <= p_lo + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_camera);
        #1;
    endtask

    task automatic mark();
        base_m = p_main;
        base_h = p_hi;
        base_l = p_lo;
    endtask

    // n pixels; the last one arrives together with frame_end
    task automatic frame(input logic [7:0] luma, input int n);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pixel_valid = 1'b1;
        pixel_luma  = luma;
        for (int i = 0; i < n - 1; i++) tick();
        frame_end = 1'b1;
        tick();
        frame_end   = 1'b0;
        pixel_valid = 1'b0;
        repeat (8) tick();
    endtask

    task automatic skip2();
        frame(8'd110, 1);
        frame(8'd110, 1);
    endtask

    task automatic do_reset();
        sys_rst_camera_n = 1'b0;
        ae_enable        = 1'b0;
        repeat (2) tick();
        sys_rst_camera_n = 1'b1;
    endtask

    task automatic enable_and_settle();
        ae_enable = 1'b1;
        repeat (4) tick();
        skip2();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sys_rst_camera_n = 1'b0;
        ae_enable   = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pixel_valid = 1'b0;
        pixel_luma  = 8'd0;
        bus_active  = 1'b0;
        repeat (3) tick();
        chk("rst_exposure", exp_m, 8'h40);
        chk("rst_manual", man_m, 0);
        chk("rst_ready", rdy_m, 0);
        chk("rst_busy", busy_m, 0);
        sys_rst_camera_n = 1'b1;
        tick();

        mark();
        ae_enable = 1'b1;
        repeat (4) tick();
        chk("en_pulse", p_main - base_m, 1);
        chk("en_manual", man_m, 1);
        chk("en_exposure", exp_m, 8'h40);
        skip2();

        mark(); frame(8'd50, 16);
        chk("dark1_exp", exp_m, 8'h44);
        chk("dark1_pulse", p_main - base_m, 1);
        mark(); frame(8'd50, 16); frame(8'd50, 16);
        chk("skipped_pulse", p_main - base_m, 0);
        chk("skipped_exp", exp_m, 8'h44);
        mark(); frame(8'd50, 16);
        chk("dark3_exp", exp_m, 8'h48);
        chk("dark3_pulse", p_main - base_m, 1);
        skip2();

        mark(); frame(8'd200, 16);
        chk("bright_exp", exp_m, 8'h44);
        chk("bright_pulse", p_main - base_m, 1);
        skip2();

        mark(); frame(8'd110, 16); frame(8'd98, 16); frame(8'd122, 16);
        chk("window_pulse", p_main - base_m, 0);
        chk("window_exp", exp_m, 8'h44);
        mark(); frame(8'd123, 16);
        chk("above_hi_exp", exp_m, 8'h40);
        chk("above_hi_pulse", p_main - base_m, 1);
        skip2();
        mark(); frame(8'd97, 16);
        chk("below_lo_exp", exp_m, 8'h44);
        chk("below_lo_pulse", p_main - base_m, 1);
        skip2();

        bus_active = 1'b1;
        mark(); frame(8'd50, 16);
        chk("bus_exp_loaded", exp_m, 8'h48);
        chk("bus_busy", busy_m, 1);
        repeat (42) tick();
        chk("bus_no_pulse", p_main - base_m, 0);
        chk("bus_exp_held", exp_m, 8'h48);
        bus_active = 1'b0;
        tick();
        chk("bus_pulse_now", rdy_m, 1);
        tick();
        chk("bus_pulse_single", rdy_m, 0);
        chk("bus_pulse_count", p_main - base_m, 1);

        frame_start = 1'b1; tick(); frame_start = 1'b0;
        pixel_valid = 1'b1; pixel_luma = 8'd50;
        repeat (8) tick();
        pixel_valid = 1'b0;
        sys_rst_camera_n = 1'b0;
        ae_enable = 1'b0;
        tick();
        chk("midrst_exp", exp_m, 8'h40);
        chk("midrst_manual", man_m, 0);
        chk("midrst_ready", rdy_m, 0);
        chk("midrst_busy", busy_m, 0);
        tick();
        sys_rst_camera_n = 1'b1;
        enable_and_settle();

        mark();
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        repeat (8) tick();
        chk("orphan_end_pulse", p_main - base_m, 0);
        chk("orphan_end_busy", busy_m, 0);

        mark();
        ae_enable = 1'b0;
        repeat (8) tick();
        chk("disable_pulse", p_main - base_m, 1);
        chk("disable_pulse_manual", last_man, 0);
        chk("disable_exp", exp_m, 8'h40);
        chk("disable_idle", busy_m, 0);

        do_reset();
        enable_and_settle();
        mark(); frame(8'd50, 16);
        chk("max_clamp_exp", exp_h, 8'hF0);
        chk("max_clamp_pulse", p_hi - base_h, 1);
        skip2();
        mark(); frame(8'd50, 16);
        chk("max_hold_exp", exp_h, 8'hF0);
        chk("max_hold_pulse", p_hi - base_h, 0);

        do_reset();
        enable_and_settle();
        mark(); frame(8'd200, 16);
        chk("min_clamp_exp", exp_l, 8'h04);
        chk("min_clamp_pulse", p_lo - base_l, 1);
        skip2();
        mark(); frame(8'd200, 16);
        chk("min_hold_exp", exp_l, 8'h04);
        chk("min_hold_pulse", p_lo - base_l, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
